// File: rtl/td4_input_debounce.sv
// TD4 DIP-switch conditioner: 2-FF synchroniser, tick-sampled per-bit debounce
// and registered rise/fall/changed strobes feeding TD4core's indata port.
module td4_input_debounce #(
  parameter int WIDTH      = 4,
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] indata,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT) + 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [PW-1:0]    r_pre;
  logic             r_tick;
  logic [WIDTH-1:0] r_indata;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;
  logic [CW-1:0]    r_cnt [WIDTH];

  logic [PW-1:0]    w_pre_nxt;
  logic             w_tick_nxt;
  logic [WIDTH-1:0] w_indata_nxt;
  logic [WIDTH-1:0] w_rise_nxt;
  logic [WIDTH-1:0] w_fall_nxt;
  logic [CW-1:0]    w_cnt_nxt [WIDTH];

  // Only r_s2 is ever looked at downstream; r_s1 may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sw_raw;
      r_s2 <= r_s1;
    end
  end

  // tick is registered so it is high exactly while r_pre sits at its last value.
  always_comb begin
    w_pre_nxt  = (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);
    w_tick_nxt = (w_pre_nxt == PRE_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= w_pre_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  // A sample equal to the current level restarts that bit's run of differing samples.
  always_comb begin
    w_indata_nxt = r_indata;
    w_rise_nxt   = '0;
    w_fall_nxt   = '0;
    w_cnt_nxt    = r_cnt;
    if (r_tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_s2[i] == r_indata[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          w_indata_nxt[i] = r_s2[i];
          w_cnt_nxt[i]    = '0;
          w_rise_nxt[i]   = r_s2[i];
          w_fall_nxt[i]   = ~r_s2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_indata  <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_indata  <= w_indata_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_changed <= |(w_rise_nxt | w_fall_nxt);
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign indata  = r_indata;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign changed = r_changed;
  assign tick    = r_tick;

endmodule
